// File: rtl/encoder_msg_buffer_pkg.sv
// Shared types and widths for the encoder message buffer.
// Contents: fetch FSM state enum, message word/length/burst-length widths.
package encoder_msg_pkg;

  localparam int MSG_WORD_W = 32;
  localparam int MSG_LEN_W  = 24;
  localparam int MSG_BLEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/encoder_msg_buffer_if.sv
// Memory-side burst read bus of the encoder message buffer.
// master: buffer side (drives request, receives ack and return data).
// slave : memory side (receives request, drives ack and return data).
interface encoder_msg_buffer_if;
  import encoder_msg_pkg::*;

  logic                  msg_burst_req;
  logic [31:0]           msg_burst_addr;
  logic [MSG_BLEN_W-1:0] msg_burst_len;
  logic                  msg_burst_ack;
  logic [MSG_WORD_W-1:0] msg_rdata;
  logic                  msg_rdata_valid;

  modport master (
    output msg_burst_req, msg_burst_addr, msg_burst_len,
    input  msg_burst_ack, msg_rdata, msg_rdata_valid
  );

  modport slave (
    input  msg_burst_req, msg_burst_addr, msg_burst_len,
    output msg_burst_ack, msg_rdata, msg_rdata_valid
  );

endinterface

// File: rtl/encoder_msg_buffer_msg_word_fifo.sv
// Single-clock DEPTH x 32 word FIFO with a registered pop output.
// Ports: clk, rst (sync, active-high), wr_en/wr_data (write dropped when full),
// rd_en (pop ignored when empty), rd_data (holds until next accepted pop),
// full, empty, level (entries stored, excluding rd_data).
module msg_word_fifo
  import encoder_msg_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [MSG_WORD_W-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [MSG_WORD_W-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int AW = $clog2(DEPTH);

  logic [MSG_WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  // A pop on an empty FIFO is never bypassed from a same-cycle write.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/encoder_msg_buffer.sv
// Message-word prefetch buffer feeding the encoder nibble FSM.
// Ports: encoder_clk, encoder_reset (sync, active-high); msg_start/msg_base_addr/
// msg_total_words start a fetch; mem is the burst read bus (master side);
// get_next_msg_word pops into next_msg_word; status: msg_infifo_empty, msg_level,
// msg_fetch_done, sticky msg_err_ovf / msg_err_udf.
//
// state | meaning
// IDLE  | waiting for msg_start
// CHECK | compute next burst, wait for buffer credit
// REQ   | burst request held until acked
// DONE  | all words requested; fetch_done once none outstanding
module encoder_msg_buffer
  import encoder_msg_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int MSG_RBURST_LEN = 16
) (
  input  logic                       encoder_clk,
  input  logic                       encoder_reset,
  input  logic                       msg_start,
  input  logic [31:0]                msg_base_addr,
  input  logic [MSG_LEN_W-1:0]       msg_total_words,
  encoder_msg_buffer_if.master       mem,
  input  logic                       get_next_msg_word,
  output logic [MSG_WORD_W-1:0]      next_msg_word,
  output logic                       msg_infifo_empty,
  output logic [$clog2(DEPTH):0]     msg_level,
  output logic                       msg_fetch_done,
  output logic                       msg_err_ovf,
  output logic                       msg_err_udf
);

  localparam int LW = $clog2(DEPTH) + 1;

  fetch_state_e          state, state_nxt;
  logic [31:0]           base_q;
  logic [MSG_LEN_W-1:0]  total_q;
  logic [MSG_LEN_W-1:0]  words_req;
  logic [LW-1:0]         outstanding;
  logic [31:0]           addr_q;
  logic [MSG_BLEN_W-1:0] len_q;
  logic [MSG_LEN_W-1:0]  rem;
  logic [MSG_BLEN_W-1:0] len_chk;
  logic [31:0]           credit_sum;
  logic                  latch_msg, issue, grant, ret_ok, fifo_full;
  logic [LW-1:0]         out_inc, out_dec;

  assign rem     = total_q - words_req;
  assign len_chk = (rem < MSG_LEN_W'(MSG_RBURST_LEN)) ? rem[MSG_BLEN_W-1:0]
                                                      : MSG_BLEN_W'(MSG_RBURST_LEN);
  // Credit covers words already buffered plus words still in flight.
  assign credit_sum = 32'(msg_level) + 32'(outstanding) + 32'(len_chk);
  // Returns with nothing outstanding are stale (e.g. after reset): not stored.
  assign ret_ok  = mem.msg_rdata_valid && (outstanding != '0);
  assign out_inc = grant ? LW'(len_q) : '0;
  assign out_dec = LW'(ret_ok);

  always_ff @(posedge encoder_clk) begin
    if (encoder_reset) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    latch_msg          = 1'b0;
    issue              = 1'b0;
    grant              = 1'b0;
    mem.msg_burst_req  = (state == REQ);
    mem.msg_burst_addr = addr_q;
    mem.msg_burst_len  = len_q;
    msg_fetch_done     = (state == DONE) && (outstanding == '0);
    case (state)
      IDLE, DONE: begin
        if (msg_start) begin
          latch_msg = 1'b1;
          state_nxt = (msg_total_words == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (rem == '0) begin
          state_nxt = DONE;
        end else if (credit_sum <= 32'(DEPTH)) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem.msg_burst_ack) begin
          grant     = 1'b1;
          state_nxt = CHECK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge encoder_clk) begin
    if (encoder_reset) begin
      base_q      <= '0;
      total_q     <= '0;
      words_req   <= '0;
      outstanding <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      msg_err_ovf <= 1'b0;
      msg_err_udf <= 1'b0;
    end else begin
      if (latch_msg) begin
        base_q    <= msg_base_addr;
        total_q   <= msg_total_words;
        words_req <= '0;
      end
      if (issue) begin
        addr_q <= base_q + 32'({words_req, 2'b00});
        len_q  <= len_chk;
      end
      if (grant) words_req <= words_req + MSG_LEN_W'(len_q);
      outstanding <= outstanding + out_inc - out_dec;
      if (mem.msg_rdata_valid && ((outstanding == '0) || fifo_full)) msg_err_ovf <= 1'b1;
      if (get_next_msg_word && msg_infifo_empty) msg_err_udf <= 1'b1;
    end
  end

  msg_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (encoder_clk),
    .rst     (encoder_reset),
    .wr_en   (ret_ok),
    .wr_data (mem.msg_rdata),
    .rd_en   (get_next_msg_word),
    .rd_data (next_msg_word),
    .full    (fifo_full),
    .empty   (msg_infifo_empty),
    .level   (msg_level)
  );

endmodule

// File: tb/tb_encoder_msg_buffer.sv
module tb_encoder_msg_buffer;
  import encoder_msg_pkg::*;

  localparam int DEPTH = 64;
  localparam int BL    = 16;

  logic        encoder_clk = 1'b0;
  logic        encoder_reset = 1'b1;
  logic        msg_start = 1'b0;
  logic [31:0] msg_base_addr = '0;
  logic [23:0] msg_total_words = '0;
  logic        get_next_msg_word = 1'b0;
  logic [31:0] next_msg_word;
  logic        msg_infifo_empty;
  logic [6:0]  msg_level;
  logic        msg_fetch_done;
  logic        msg_err_ovf;
  logic        msg_err_udf;

  encoder_msg_buffer_if mem();

  encoder_msg_buffer #(.DEPTH(DEPTH), .MSG_RBURST_LEN(BL)) dut (
    .encoder_clk       (encoder_clk),
    .encoder_reset     (encoder_reset),
    .msg_start         (msg_start),
    .msg_base_addr     (msg_base_addr),
    .msg_total_words   (msg_total_words),
    .mem               (mem.master),
    .get_next_msg_word (get_next_msg_word),
    .next_msg_word     (next_msg_word),
    .msg_infifo_empty  (msg_infifo_empty),
    .msg_level         (msg_level),
    .msg_fetch_done    (msg_fetch_done),
    .msg_err_ovf       (msg_err_ovf),
    .msg_err_udf       (msg_err_udf)
  );

  always #5 encoder_clk = ~encoder_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word queue, a list of bursts still to be granted,
  // a count of words in flight and the sticky flags.
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic [31:0] mq[$];
  burst_t      bq[$];
  burst_t      b;
  logic [31:0] m_next;
  int          m_out, m_sz, l;
  bit          m_ovf, m_udf, m_started;
  bit          cmp_en = 1'b0;

  // Compare the outputs produced by the previous edge, then advance the model
  // with the inputs the next edge will sample.
  initial forever begin
    @(negedge encoder_clk);
    if (cmp_en) begin
      chk("level", 32'(msg_level), 32'(mq.size()));
      chk("empty", 32'(msg_infifo_empty), 32'(mq.size() == 0));
      chk("next_word", next_msg_word, m_next);
      chk("err_ovf", 32'(msg_err_ovf), 32'(m_ovf));
      chk("err_udf", 32'(msg_err_udf), 32'(m_udf));
      chk("fetch_done", 32'(msg_fetch_done), 32'(m_started && bq.size() == 0 && m_out == 0));
    end
    if (encoder_reset) begin
      mq.delete(); bq.delete();
      m_next = '0; m_out = 0; m_ovf = 0; m_udf = 0; m_started = 0;
    end else begin
      m_sz = mq.size();
      if (get_next_msg_word) begin
        if (m_sz > 0) m_next = mq.pop_front();
        else          m_udf = 1;
      end
      if (mem.msg_rdata_valid) begin
        if (m_out == 0) m_ovf = 1;
        else begin
          m_out--;
          if (m_sz >= DEPTH) m_ovf = 1;
          else               mq.push_back(mem.msg_rdata);
        end
      end
      if (mem.msg_burst_ack && bq.size() > 0) begin
        m_out += int'(bq[0].len);
        void'(bq.pop_front());
      end
      if (msg_start) begin
        bq.delete();
        for (int w = 0; w < int'(msg_total_words); w += l) begin
          l = (int'(msg_total_words) - w < BL) ? int'(msg_total_words) - w : BL;
          b.addr = msg_base_addr + 32'(w * 4);
          b.len  = 8'(l);
          bq.push_back(b);
        end
        m_started = 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge encoder_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    encoder_reset = 1'b1;
    msg_start = 1'b0; get_next_msg_word = 1'b0;
    mem.msg_burst_ack = 1'b0; mem.msg_rdata_valid = 1'b0;
    tick(2);
    encoder_reset = 1'b0;
  endtask

  task automatic start_msg(input logic [31:0] base, input logic [23:0] total);
    msg_start = 1'b1; msg_base_addr = base; msg_total_words = total;
    tick();
    msg_start = 1'b0;
  endtask

  task automatic ack_burst(input int dly, output logic [31:0] a, output logic [7:0] ln);
    int n = 0;
    a = '0; ln = '0;
    while (!mem.msg_burst_req && n < 100) begin
      tick();
      n++;
    end
    if (!mem.msg_burst_req) begin
      chk("req_timeout", 32'(mem.msg_burst_req), 32'd1);
      return;
    end
    a = mem.msg_burst_addr; ln = mem.msg_burst_len;
    if (bq.size() > 0) begin
      chk("burst_addr", a, bq[0].addr);
      chk("burst_len", 32'(ln), 32'(bq[0].len));
    end else chk("burst_unexpected", 32'd1, 32'd0);
    repeat (dly) begin
      tick();
      chk("hold_req", 32'(mem.msg_burst_req), 32'd1);
      chk("hold_addr", mem.msg_burst_addr, a);
      chk("hold_len", 32'(mem.msg_burst_len), 32'(ln));
    end
    mem.msg_burst_ack = 1'b1;
    tick();
    mem.msg_burst_ack = 1'b0;
    chk("req_drop", 32'(mem.msg_burst_req), 32'd0);
  endtask

  task automatic ret_words(input int n, input logic [31:0] v0);
    for (int i = 0; i < n; i++) begin
      mem.msg_rdata_valid = 1'b1;
      mem.msg_rdata = v0 + 32'(i);
      tick();
    end
    mem.msg_rdata_valid = 1'b0;
  endtask

  task automatic pop(input int n);
    get_next_msg_word = 1'b1;
    tick(n);
    get_next_msg_word = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(mem.msg_burst_req), 32'd0);
    chk({tag, "_addr"}, mem.msg_burst_addr, 32'd0);
    chk({tag, "_len"}, 32'(mem.msg_burst_len), 32'd0);
    chk({tag, "_next"}, next_msg_word, 32'd0);
    chk({tag, "_empty"}, 32'(msg_infifo_empty), 32'd1);
    chk({tag, "_level"}, 32'(msg_level), 32'd0);
    chk({tag, "_done"}, 32'(msg_fetch_done), 32'd0);
    chk({tag, "_ovf"}, 32'(msg_err_ovf), 32'd0);
    chk({tag, "_udf"}, 32'(msg_err_udf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  logic [31:0] a;
  logic [7:0]  ln;

  initial begin
    mem.msg_burst_ack = 1'b0; mem.msg_rdata = '0; mem.msg_rdata_valid = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    chk_reset_vals("rst");

    // 40 words from 0x1000_0000: bursts of 16, 16, 8
    start_msg(32'h1000_0000, 24'd40);
    chk("req_not_early", 32'(mem.msg_burst_req), 32'd0);
    ack_burst(0, a, ln);
    chk("b0_addr", a, 32'h1000_0000); chk("b0_len", 32'(ln), 32'd16);
    ret_words(16, 32'h100);
    ack_burst(0, a, ln);
    chk("b1_addr", a, 32'h1000_0040); chk("b1_len", 32'(ln), 32'd16);
    ret_words(16, 32'h110);
    ack_burst(0, a, ln);
    chk("b2_addr", a, 32'h1000_0080); chk("b2_len", 32'(ln), 32'd8);
    ret_words(8, 32'h120);
    chk("done_40", 32'(msg_fetch_done), 32'd1);
    chk("level_40", 32'(msg_level), 32'd40);
    pop(40);
    chk("next_last_40", next_msg_word, 32'h127);
    tick();

    // credit: 100 words, consumer idle, fifth burst waits for level <= 48
    do_reset();
    start_msg(32'h2000_0000, 24'd100);
    for (int k = 0; k < 4; k++) begin
      ack_burst(0, a, ln);
      ret_words(16, 32'h200 + 32'(16 * k));
    end
    chk("level_full", 32'(msg_level), 32'd64);
    tick(3);
    chk("credit_block", 32'(mem.msg_burst_req), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      pop(1);
      tick();
      chk("credit_hold", 32'(mem.msg_burst_req), 32'd0);
      chk("credit_level", 32'(msg_level), 32'(64 - k));
    end
    pop(1);
    tick();
    chk("credit_release", 32'(mem.msg_burst_req), 32'd1);
    chk("b4_addr", mem.msg_burst_addr, 32'h2000_0100);

    // A0..A3 popped on consecutive cycles
    do_reset();
    start_msg(32'h3000_0000, 24'd4);
    ack_burst(0, a, ln);
    ret_words(4, 32'hA0);
    get_next_msg_word = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pop_seq", next_msg_word, 32'hA0 + 32'(i));
    end
    get_next_msg_word = 1'b0;
    chk("pop_level0", 32'(msg_level), 32'd0);
    chk("pop_empty1", 32'(msg_infifo_empty), 32'd1);

    // underflow, then simultaneous write and pop on an empty FIFO
    pop(1);
    chk("udf_next_hold", next_msg_word, 32'hA3);
    chk("udf_set", 32'(msg_err_udf), 32'd1);
    start_msg(32'h4000_0000, 24'd1);
    ack_burst(0, a, ln);
    mem.msg_rdata_valid = 1'b1; mem.msg_rdata = 32'hBEEF; get_next_msg_word = 1'b1;
    tick();
    mem.msg_rdata_valid = 1'b0; get_next_msg_word = 1'b0;
    chk("wr_rd_empty_level", 32'(msg_level), 32'd1);
    chk("wr_rd_empty_next", next_msg_word, 32'hA3);
    pop(1);
    chk("wr_rd_pop", next_msg_word, 32'hBEEF);
    tick(5);
    chk("udf_sticky", 32'(msg_err_udf), 32'd1);

    // ack delayed 5 cycles, single grant
    start_msg(32'h5000_0000, 24'd2);
    ack_burst(5, a, ln);
    chk("dly_addr", a, 32'h5000_0000); chk("dly_len", 32'(ln), 32'd2);
    ret_words(2, 32'h500);
    chk("dly_done", 32'(msg_fetch_done), 32'd1);
    chk("dly_ovf", 32'(msg_err_ovf), 32'd0);

    // reset with 8 words outstanding, then a stale return
    start_msg(32'h6000_0000, 24'd8);
    ack_burst(0, a, ln);
    encoder_reset = 1'b1;
    tick();
    encoder_reset = 1'b0;
    chk_reset_vals("midrst");
    mem.msg_rdata_valid = 1'b1; mem.msg_rdata = 32'h600;
    tick();
    mem.msg_rdata_valid = 1'b0;
    chk("stale_ovf", 32'(msg_err_ovf), 32'd1);
    chk("stale_level", 32'(msg_level), 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
